// File: rtl/sound_sequencer.sv
// ---------------------------------------------------------------------------
// sound_sequencer
//
// Schedules game sound effects onto a single tone datapath made of a
// sin-table address counter and a frequency prescaler. One-cycle sound
// requests are latched into a pending set and served by fixed priority,
// where index 0 is the highest. The selected effect's note list is read from
// an external synchronous note ROM. Each entry is {freq_div, duration}, and a
// duration of zero marks the end of the list.
//
// Ports
//   clk         in   system clock
//   resetN      in   asynchronous active-low reset
//   tick        in   1-cycle duration strobe; note lengths count these
//   mute        in   forces sound_en low; sequencing keeps running
//   req         in   [NUM_SRC] 1-cycle request pulses, one bit per effect
//   rom_addr    out  [ROM_AW] {cur_src, note_idx} to the note ROM
//   rom_data    in   [DIV_W+DUR_W] {freq_div, duration}, valid 1 cycle after rom_addr
//   sound_en    out  tone enable for the address counter
//   freq_div    out  [DIV_W] prescaler divide value; holds after an effect ends
//   note_start  out  1-cycle pulse in the cycle a note is loaded
//   busy        out  high whenever the sequencer is not idle
//   cur_src     out  [SRC_W] effect currently being sequenced
//
// No valid/ready handshakes are used. A req pulse is a fire-and-forget event
// that is captured in pending. A ROM read has a fixed latency of one cycle:
// the address is stable in FETCH, and the data is sampled in LOAD.
// ---------------------------------------------------------------------------
module sound_sequencer #(
    parameter int NUM_SRC    = 4,
    parameter int NOTE_IDX_W = 3,
    parameter int DIV_W      = 16,
    parameter int DUR_W      = 8,
    localparam int SRC_W     = $clog2(NUM_SRC),
    localparam int ROM_AW    = SRC_W + NOTE_IDX_W
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   tick,
    input  logic                   mute,
    input  logic [NUM_SRC-1:0]     req,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [DIV_W+DUR_W-1:0] rom_data,
    output logic                   sound_en,
    output logic [DIV_W-1:0]       freq_div,
    output logic                   note_start,
    output logic                   busy,
    output logic [SRC_W-1:0]       cur_src
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [SRC_W-1:0]      cur_src_q, cur_src_d;
    logic [NOTE_IDX_W-1:0] note_idx_q, note_idx_d;
    logic [DUR_W-1:0]      dur_cnt_q, dur_cnt_d;
    logic [DIV_W-1:0]      freq_div_q, freq_div_d;

    logic [DIV_W-1:0]      rom_freq;
    logic [DUR_W-1:0]      rom_dur;
    logic                  pick_valid;
    logic [SRC_W-1:0]      pick_idx;
    logic                  preempt;
    logic                  take;
    logic [NUM_SRC-1:0]    set_mask;
    logic [NUM_SRC-1:0]    clr_mask;
    logic [NUM_SRC-1:0]    drop_mask;
    logic                  note_start_c;

    assign rom_freq = rom_data[DIV_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    // Lowest-index pending source. The same pick serves both IDLE selection
    // and preemption. Any pending j < cur_src is necessarily the lowest set bit.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_valid = 1'b1;
                pick_idx   = SRC_W'(i);
            end
        end
    end

    assign preempt = (state_q != S_IDLE) && pick_valid && (pick_idx < cur_src_q);
    assign take    = ((state_q == S_IDLE) && pick_valid) || preempt;

    // A re-request of the effect already playing is ignored rather than
    // queued for a replay.
    assign drop_mask = (state_q != S_IDLE) ? (NUM_SRC'(1) << cur_src_q) : '0;
    assign set_mask  = req & ~drop_mask;
    assign clr_mask  = take ? (NUM_SRC'(1) << pick_idx) : '0;

    always_comb begin
        state_d      = state_q;
        cur_src_d    = cur_src_q;
        note_idx_d   = note_idx_q;
        dur_cnt_d    = dur_cnt_q;
        freq_div_d   = freq_div_q;
        note_start_c = 1'b0;
        pending_d    = set_mask | (pending_q & ~clr_mask);

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    cur_src_d  = pick_idx;
                    note_idx_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (rom_dur == '0) begin
                    state_d = S_IDLE;
                end else begin
                    freq_div_d   = rom_freq;
                    dur_cnt_d    = rom_dur;
                    note_start_c = 1'b1;
                    state_d      = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (dur_cnt_q == DUR_W'(1)) begin
                        // The effect stops after its last slot. The note index
                        // does not wrap back to zero.
                        if (&note_idx_q) begin
                            state_d = S_IDLE;
                        end else begin
                            note_idx_d = note_idx_q + NOTE_IDX_W'(1);
                            state_d    = S_FETCH;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A higher-priority request overrides whatever the current state
        // decided. This includes a note load or an end marker in the same
        // cycle. The preempted effect is abandoned.
        if (preempt) begin
            cur_src_d    = pick_idx;
            note_idx_d   = '0;
            dur_cnt_d    = dur_cnt_q;
            freq_div_d   = freq_div_q;
            note_start_c = 1'b0;
            state_d      = S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            cur_src_q  <= '0;
            note_idx_q <= '0;
            dur_cnt_q  <= '0;
            freq_div_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cur_src_q  <= cur_src_d;
            note_idx_q <= note_idx_d;
            dur_cnt_q  <= dur_cnt_d;
            freq_div_q <= freq_div_d;
        end
    end

    assign rom_addr   = {cur_src_q, note_idx_q};
    assign freq_div   = freq_div_q;
    assign cur_src    = cur_src_q;
    assign busy       = (state_q != S_IDLE);
    assign sound_en   = (state_q == S_PLAY) && !mute;
    assign note_start = note_start_c;

endmodule

// File: tb/tb_sound_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sound_sequencer
//
// Directed bench for sound_sequencer. A behavioural synchronous note ROM
// holds four effects:
//   src0: eight one-tick notes, 100..107
//   src1: {1000,3} {2000,2} end
//   src2: {300,2} end
//   src3: {400,5} {500,5} end
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_sound_sequencer;

    logic        clk;
    logic        resetN;
    logic        tick;
    logic        mute;
    logic [3:0]  req;
    logic [4:0]  rom_addr;
    logic [23:0] rom_data;
    logic        sound_en;
    logic [15:0] freq_div;
    logic        note_start;
    logic        busy;
    logic [1:0]  cur_src;

    logic [23:0] rom [32];

    int checks;
    int errors;

    sound_sequencer dut (
        .clk        (clk),
        .resetN     (resetN),
        .tick       (tick),
        .mute       (mute),
        .req        (req),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sound_en   (sound_en),
        .freq_div   (freq_div),
        .note_start (note_start),
        .busy       (busy),
        .cur_src    (cur_src)
    );

    // ---------------- clock / reset / ROM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rom_data = '0;
    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic t, input logic [3:0] r);
        tick = t;
        req  = r;
        @(posedge clk);
        #1;
        tick = 1'b0;
        req  = 4'b0;
    endtask

    // n ticks, one every 'period' clocks. The bench counts how many observed
    // cycles had sound_en high. The cycle after the last tick is not counted.
    task automatic run_ticks(input int n, input int period, output int en_cycles);
        en_cycles = 0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < period - 1; c++) begin
                cyc(1'b0, 4'b0);
                if (sound_en) en_cycles++;
            end
            cyc(1'b1, 4'b0);
            if (sound_en && k != n - 1) en_cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 1'b0;
        tick   = 1'b0;
        mute   = 1'b0;
        req    = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, sound_en, note_start, cur_src, rom_addr, freq_div} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b en=%0b ns=%0b src=%0d addr=%0d div=%0d required all 0",
                     busy, sound_en, note_start, cur_src, rom_addr, freq_div);
        end
        @(negedge clk);
        resetN = 1'b1;
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_basic_effect();
        int en;
        cyc(1'b0, 4'b0010);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t1_pending_only got busy=%0b required 0", busy); end
        cyc(1'b0, 4'b0);
        checks++;
        if (busy !== 1'b1 || cur_src !== 2'd1 || rom_addr !== 5'd8 || sound_en !== 1'b0) begin
            errors++;
            $display("FAIL t1_fetch got busy=%0b src=%0d addr=%0d en=%0b required 1 1 8 0", busy, cur_src, rom_addr, sound_en);
        end
        cyc(1'b0, 4'b0);
        checks++;
        if (note_start !== 1'b1 || sound_en !== 1'b0) begin
            errors++;
            $display("FAIL t1_load1 got ns=%0b en=%0b required 1 0", note_start, sound_en);
        end
        cyc(1'b0, 4'b0);
        checks++;
        if (freq_div !== 16'd1000 || sound_en !== 1'b1 || note_start !== 1'b0) begin
            errors++;
            $display("FAIL t1_play1 got div=%0d en=%0b ns=%0b required 1000 1 0", freq_div, sound_en, note_start);
        end
        run_ticks(3, 10, en);
        checks++;
        if (en !== 29) begin errors++; $display("FAIL t1_note1_len got %0d required 29", en); end
        checks++;
        if (sound_en !== 1'b0 || rom_addr !== 5'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_gap got en=%0b addr=%0d busy=%0b required 0 9 1", sound_en, rom_addr, busy);
        end
        cyc(1'b0, 4'b0);
        checks++;
        if (note_start !== 1'b1 || sound_en !== 1'b0) begin
            errors++;
            $display("FAIL t1_load2 got ns=%0b en=%0b required 1 0", note_start, sound_en);
        end
        cyc(1'b0, 4'b0);
        checks++;
        if (freq_div !== 16'd2000 || sound_en !== 1'b1) begin
            errors++;
            $display("FAIL t1_play2 got div=%0d en=%0b required 2000 1", freq_div, sound_en);
        end
        run_ticks(2, 10, en);
        checks++;
        if (en !== 19) begin errors++; $display("FAIL t1_note2_len got %0d required 19", en); end
        cyc(1'b0, 4'b0);
        checks++;
        if (busy !== 1'b1 || note_start !== 1'b0) begin
            errors++;
            $display("FAIL t1_end_marker got busy=%0b ns=%0b required 1 0", busy, note_start);
        end
        cyc(1'b0, 4'b0);
        checks++;
        if (busy !== 1'b0 || freq_div !== 16'd2000 || sound_en !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle got busy=%0b div=%0d en=%0b required 0 2000 0", busy, freq_div, sound_en);
        end
    endtask

    task automatic test_priority_and_preempt();
        int en;
        cyc(1'b0, 4'b1100);
        cyc(1'b0, 4'b0);
        checks++;
        if (cur_src !== 2'd2 || rom_addr !== 5'd16) begin
            errors++;
            $display("FAIL t2_pick_src2 got src=%0d addr=%0d required 2 16", cur_src, rom_addr);
        end
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        checks++;
        if (freq_div !== 16'd300 || sound_en !== 1'b1) begin
            errors++;
            $display("FAIL t2_play got div=%0d en=%0b required 300 1", freq_div, sound_en);
        end
        run_ticks(2, 3, en);
        checks++;
        if (en !== 5) begin errors++; $display("FAIL t2_note_len got %0d required 5", en); end
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle_gap got busy=%0b required 0", busy); end
        cyc(1'b0, 4'b0);
        checks++;
        if (busy !== 1'b1 || cur_src !== 2'd3 || rom_addr !== 5'd24) begin
            errors++;
            $display("FAIL t2_src3_start got busy=%0b src=%0d addr=%0d required 1 3 24", busy, cur_src, rom_addr);
        end
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        checks++;
        if (freq_div !== 16'd400 || sound_en !== 1'b1) begin
            errors++;
            $display("FAIL t3_src3_play got div=%0d en=%0b required 400 1", freq_div, sound_en);
        end
        cyc(1'b1, 4'b0001);
        checks++;
        if (cur_src !== 2'd3 || sound_en !== 1'b1) begin
            errors++;
            $display("FAIL t3_req_latched got src=%0d en=%0b required 3 1", cur_src, sound_en);
        end
        cyc(1'b0, 4'b0);
        checks++;
        if (busy !== 1'b1 || cur_src !== 2'd0 || rom_addr !== 5'd0 || sound_en !== 1'b0) begin
            errors++;
            $display("FAIL t3_preempt got busy=%0b src=%0d addr=%0d en=%0b required 1 0 0 0", busy, cur_src, rom_addr, sound_en);
        end
    endtask

    task automatic test_eight_notes();
        int starts;
        starts = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 4'b0);
            if (note_start) starts++;
            cyc(1'b0, 4'b0);
            checks++;
            if (freq_div !== 16'(100 + k)) begin
                errors++;
                $display("FAIL t4_note_div got %0d required %0d", freq_div, 100 + k);
            end
            cyc(1'b1, 4'b0);
        end
        checks++;
        if (starts !== 8) begin errors++; $display("FAIL t4_start_count got %0d required 8", starts); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t4_idle_after_7 got busy=%0b required 0", busy); end
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 4'b0);
            if (busy !== 1'b0 || note_start !== 1'b0) starts = 100;
        end
        checks++;
        if (starts !== 8) begin
            errors++;
            $display("FAIL t4_no_resume got activity after end (busy=%0b) required idle", busy);
        end
    endtask

    task automatic test_mute_and_drop();
        int en;
        mute = 1'b1;
        cyc(1'b0, 4'b0010);
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        checks++;
        if (sound_en !== 1'b0 || freq_div !== 16'd1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_mute_play got en=%0b div=%0d busy=%0b required 0 1000 1", sound_en, freq_div, busy);
        end
        cyc(1'b0, 4'b0010);
        run_ticks(3, 4, en);
        checks++;
        if (en !== 0 || rom_addr !== 5'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_mute_timing got en=%0d addr=%0d busy=%0b required 0 9 1", en, rom_addr, busy);
        end
        mute = 1'b0;
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        checks++;
        if (freq_div !== 16'd2000 || sound_en !== 1'b1) begin
            errors++;
            $display("FAIL t5_unmute got div=%0d en=%0b required 2000 1", freq_div, sound_en);
        end
        run_ticks(2, 4, en);
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        en = 0;
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 4'b0);
            if (busy) en++;
        end
        checks++;
        if (en !== 0) begin errors++; $display("FAIL t5_no_replay got %0d busy cycles required 0", en); end
    endtask

    task automatic test_async_reset();
        int bad;
        cyc(1'b0, 4'b0010);
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0);
        cyc(1'b0, 4'b0100);
        cyc(1'b0, 4'b0);
        checks++;
        if (cur_src !== 2'd1 || sound_en !== 1'b1) begin
            errors++;
            $display("FAIL t6_no_preempt got src=%0d en=%0b required 1 1", cur_src, sound_en);
        end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({busy, sound_en, note_start, cur_src, rom_addr, freq_div} !== 26'd0) begin
            errors++;
            $display("FAIL t6_async_reset got busy=%0b en=%0b ns=%0b src=%0d addr=%0d div=%0d required all 0",
                     busy, sound_en, note_start, cur_src, rom_addr, freq_div);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 4'b0);
            if (busy !== 1'b0 || cur_src !== 2'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL t6_stay_idle got %0d non-idle cycles required 0", bad); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 32; a++) rom[a] = 24'd0;
        for (int k = 0; k < 8; k++) rom[k] = {16'(100 + k), 8'd1};
        rom[8]  = {16'd1000, 8'd3};
        rom[9]  = {16'd2000, 8'd2};
        rom[16] = {16'd300, 8'd2};
        rom[24] = {16'd400, 8'd5};
        rom[25] = {16'd500, 8'd5};

        test_reset();
        test_basic_effect();
        test_priority_and_preempt();
        test_eight_notes();
        test_mute_and_drop();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
